// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and writeback for R-type, lw, sw, beq, addi and j.
// Memory states wait on mem_ready_i so that one multicycle memory can serve
// both instruction and data accesses.
//
// Optional feature macro: MIPS_CTRL_BNE_EN adds bne (opcode 000101) and the
// branch_ne_o port. Without it, 000101 is treated as an illegal opcode.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   opcode_i        instr[31:26] from the IR, captured in DECODE
//   mem_ready_i     memory completes the current access this cycle
//   pc_write_o      unconditional PC load
//   branch_o        PC load qualified by ALU zero (beq)
//   iord_o          memory address select, 0 = PC, 1 = ALUOut
//   mem_req_o       memory access request
//   mem_write_o     store strobe, only meaningful with mem_req_o
//   ir_write_o      instruction register load
//   reg_dst_o       register file write address, 1 = rd, 0 = rt
//   mem_to_reg_o    register file write data, 1 = MDR, 0 = ALUOut
//   reg_write_o     register file write enable
//   alu_src_a_o     0 = PC, 1 = register A
//   alu_src_b_o     00 = B, 01 = 4, 10 = sext imm, 11 = sext imm << 2
//   alu_op_o        ALU decoder mode, 00 add, 01 sub, 10 funct
//   pc_src_o        00 = ALU result, 01 = ALUOut, 10 = jump target
//   branch_ne_o     PC load qualified by !zero (only with MIPS_CTRL_BNE_EN)
//   illegal_op_o    one-cycle pulse after an unknown opcode is decoded
//   retired_o       count of completed instructions, wraps
module mips_multicycle_ctrl #(
  parameter int unsigned OPCODE_W     = 6,
  parameter int unsigned ALUOP_W      = 2,
  parameter int unsigned RETIRE_CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_W-1:0]     opcode_i,
  input  logic                    mem_ready_i,
  output logic                    pc_write_o,
  output logic                    branch_o,
  output logic                    iord_o,
  output logic                    mem_req_o,
  output logic                    mem_write_o,
  output logic                    ir_write_o,
  output logic                    reg_dst_o,
  output logic                    mem_to_reg_o,
  output logic                    reg_write_o,
  output logic                    alu_src_a_o,
  output logic [1:0]              alu_src_b_o,
  output logic [ALUOP_W-1:0]      alu_op_o,
  output logic [1:0]              pc_src_o,
`ifdef MIPS_CTRL_BNE_EN
  output logic                    branch_ne_o,
`endif
  output logic                    illegal_op_o,
  output logic [RETIRE_CNT_W-1:0] retired_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JMP    = 4'd11;
`ifdef MIPS_CTRL_BNE_EN
  localparam logic [3:0] S_BNE    = 4'd12;
  localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(6'b000101);
`endif

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2'b10);

  logic [3:0]              state_q, state_d;
  logic [OPCODE_W-1:0]     op_q, op_d;
  logic [RETIRE_CNT_W-1:0] retired_q, retired_d;
  logic                    illegal_q, illegal_d;
  logic                    retire;

  // State, latched opcode, illegal pulse and retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and state-decoded datapath controls; everything is held at
  // zero while rst is asserted so no strobe reaches the datapath in reset.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    illegal_d    = 1'b0;
    retire       = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    iord_o       = 1'b0;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = ALU_ADD;
    pc_src_o     = 2'b00;
`ifdef MIPS_CTRL_BNE_EN
    branch_ne_o  = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
          if (mem_ready_i) state_d = S_DECODE;
        end
        S_DECODE: begin
          // ALU precomputes the branch target while the opcode is decoded
          alu_src_b_o = 2'b11;
          op_d        = opcode_i;
          case (opcode_i)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BEQ;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JMP;
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE:       state_d = S_BNE;
`endif
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          state_d     = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req_o = 1'b1;
          iord_o    = 1'b1;
          if (mem_ready_i) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          state_d      = S_FETCH;
          retire       = 1'b1;
        end
        S_MEMWR: begin
          mem_req_o   = 1'b1;
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
          if (mem_ready_i) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
        S_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_FN;
          state_d     = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
          state_d     = S_FETCH;
          retire      = 1'b1;
        end
        S_BEQ: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          branch_o    = 1'b1;
          pc_src_o    = 2'b01;
          state_d     = S_FETCH;
          retire      = 1'b1;
        end
`ifdef MIPS_CTRL_BNE_EN
        S_BNE: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = ALU_SUB;
          branch_ne_o = 1'b1;
          pc_src_o    = 2'b01;
          state_d     = S_FETCH;
          retire      = 1'b1;
        end
`endif
        S_ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          state_d     = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write_o = 1'b1;
          state_d     = S_FETCH;
          retire      = 1'b1;
        end
        S_JMP: begin
          pc_write_o = 1'b1;
          pc_src_o   = 2'b10;
          state_d    = S_FETCH;
          retire     = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
    retired_d = retired_q + RETIRE_CNT_W'(retire);
  end

  assign illegal_op_o = illegal_q;
  assign retired_o    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl. Each issued instruction pushes an expected
// per-instruction signature (cycle count and how many cycles each kind of
// control pattern appears) derived from the instruction class and the wait
// states chosen. A monitor folds the DUT outputs into the same signature and
// closes an instruction when retired changes or illegal_op pulses.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CW = 4;

  typedef enum int {C_R, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_BNE, C_ILL} cls_t;

  typedef struct {
    int op;
    int cycles;
    int fetch_ok;
    int ir_w;
    int pc_w;
    int dec_ok;
    int addr_ok;
    int mem_rd;
    int mem_wr;
    int reg_w;
    int wb_mdr;
    int wb_rd;
    int wb_alu_rt;
    int funct_ok;
    int sub_ok;
    int br;
    int bne;
    int jmp;
    int illegal;
    int retired;
  } sig_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, branch, iord, mem_req, mem_write, ir_write;
  logic          reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic          branch_ne;
  logic          illegal_op;
  logic [CW-1:0] retired;

  int   n_chk = 0;
  int   n_pass = 0;
  int   model_ret = 0;
  bit   mon_en = 1'b0;
  sig_t exp_q[$];

  always #5 clk = ~clk;

`ifndef MIPS_CTRL_BNE_EN
  assign branch_ne = 1'b0;
`endif

  mips_multicycle_ctrl #(.OPCODE_W(6), .ALUOP_W(2), .RETIRE_CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode_i     (opcode),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .branch_o     (branch),
    .iord_o       (iord),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_dst_o    (reg_dst),
    .mem_to_reg_o (mem_to_reg),
    .reg_write_o  (reg_write),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .pc_src_o     (pc_src),
`ifdef MIPS_CTRL_BNE_EN
    .branch_ne_o  (branch_ne),
`endif
    .illegal_op_o (illegal_op),
    .retired_o    (retired)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'b000000: return C_R;
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      6'b000101: begin
`ifdef MIPS_CTRL_BNE_EN
        return C_BNE;
`else
        return C_ILL;
`endif
      end
      default: return C_ILL;
    endcase
  endfunction

  function automatic int strobes();
    return int'({pc_write, branch, iord, mem_req, mem_write, ir_write, reg_dst,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                 branch_ne});
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // One clock cycle of stimulus: inputs held for the cycle, then the edge
  task automatic cyc(input logic mr, input logic [5:0] op);
    mem_ready = mr;
    opcode    = op;
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected signature from instruction class and waits
  task automatic issue(input logic [5:0] op, input int fw, input int mw);
    cls_t c = classify(op);
    sig_t e = '{default: 0};
    int   tail;
    case (c)
      C_R, C_ADDI:       tail = 2;
      C_LW:              tail = 3 + mw;
      C_SW:              tail = 2 + mw;
      C_BEQ, C_BNE, C_J: tail = 1;
      default:           tail = 0;
    endcase
    e.op        = int'(op);
    e.cycles    = 2 + fw + tail;
    e.fetch_ok  = fw + 1;
    e.ir_w      = 1;
    e.pc_w      = (c == C_J) ? 2 : 1;
    e.dec_ok    = 1;
    e.addr_ok   = (c == C_LW || c == C_SW || c == C_ADDI) ? 1 : 0;
    e.mem_rd    = (c == C_LW) ? mw + 1 : 0;
    e.mem_wr    = (c == C_SW) ? mw + 1 : 0;
    e.reg_w     = (c == C_R || c == C_ADDI || c == C_LW) ? 1 : 0;
    e.wb_mdr    = (c == C_LW) ? 1 : 0;
    e.wb_rd     = (c == C_R) ? 1 : 0;
    e.wb_alu_rt = (c == C_ADDI) ? 1 : 0;
    e.funct_ok  = (c == C_R) ? 1 : 0;
    e.sub_ok    = (c == C_BEQ || c == C_BNE) ? 1 : 0;
    e.br        = (c == C_BEQ) ? 1 : 0;
    e.bne       = (c == C_BNE) ? 1 : 0;
    e.jmp       = (c == C_J) ? 1 : 0;
    e.illegal   = (c == C_ILL) ? 1 : 0;
    if (c != C_ILL) model_ret = (model_ret + 1) % (1 << CW);
    e.retired   = model_ret;
    exp_q.push_back(e);

    for (int i = 0; i < fw; i++) cyc(1'b0, rop());
    cyc(1'b1, rop());
    cyc(rbit(), op);
    case (c)
      C_R, C_ADDI: begin
        cyc(rbit(), rop());
        cyc(rbit(), rop());
      end
      C_LW: begin
        cyc(rbit(), rop());
        for (int i = 0; i < mw; i++) cyc(1'b0, rop());
        cyc(1'b1, rop());
        cyc(rbit(), rop());
      end
      C_SW: begin
        cyc(rbit(), rop());
        for (int i = 0; i < mw; i++) cyc(1'b0, rop());
        cyc(1'b1, rop());
      end
      C_BEQ, C_BNE, C_J: cyc(rbit(), rop());
      default: ;
    endcase
  endtask

  task automatic random_instr();
    logic [5:0] ops [8];
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;
    ops[6] = 6'b000101; ops[7] = rop();
    op = ops[$urandom_range(0, 7)];
    issue(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      cyc(1'b0, rop());
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic compare_sig(input sig_t a, input sig_t e);
    string p = $sformatf("op%06b_", e.op[5:0]);
    chk({p, "cycles"},    a.cycles,    e.cycles);
    chk({p, "fetch"},     a.fetch_ok,  e.fetch_ok);
    chk({p, "ir_write"},  a.ir_w,      e.ir_w);
    chk({p, "pc_write"},  a.pc_w,      e.pc_w);
    chk({p, "decode"},    a.dec_ok,    e.dec_ok);
    chk({p, "addr_calc"}, a.addr_ok,   e.addr_ok);
    chk({p, "mem_rd"},    a.mem_rd,    e.mem_rd);
    chk({p, "mem_wr"},    a.mem_wr,    e.mem_wr);
    chk({p, "reg_write"}, a.reg_w,     e.reg_w);
    chk({p, "wb_mdr"},    a.wb_mdr,    e.wb_mdr);
    chk({p, "wb_rd"},     a.wb_rd,     e.wb_rd);
    chk({p, "wb_alu_rt"}, a.wb_alu_rt, e.wb_alu_rt);
    chk({p, "alu_funct"}, a.funct_ok,  e.funct_ok);
    chk({p, "alu_sub"},   a.sub_ok,    e.sub_ok);
    chk({p, "branch"},    a.br,        e.br);
    chk({p, "branch_ne"}, a.bne,       e.bne);
    chk({p, "jump"},      a.jmp,       e.jmp);
    chk({p, "illegal"},   a.illegal,   e.illegal);
    chk({p, "retired"},   a.retired,   e.retired);
  endtask

  // Monitor: fold outputs into a signature, close on retire or illegal pulse
  initial begin : monitor
    sig_t          rec;
    sig_t          e;
    bit            was_en;
    logic [CW-1:0] last_ret;
    was_en = 1'b0;
    rec    = '{default: 0};
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        was_en = 1'b0;
        continue;
      end
      if (!was_en) begin
        rec      = '{default: 0};
        last_ret = retired;
        was_en   = 1'b1;
      end else if (retired !== last_ret || illegal_op === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL spurious_end: retired=%0d illegal_op=%0b with nothing outstanding",
                   retired, illegal_op);
        end else begin
          e           = exp_q.pop_front();
          rec.illegal = int'(illegal_op);
          rec.retired = int'(retired);
          compare_sig(rec, e);
        end
        rec      = '{default: 0};
        last_ret = retired;
      end
      rec.cycles++;
      if (mem_req && !iord && !mem_write && !alu_src_a && alu_src_b == 2'b01 &&
          alu_op == 2'b00 && pc_src == 2'b00) rec.fetch_ok++;
      rec.ir_w += int'(ir_write);
      rec.pc_w += int'(pc_write);
      if (!mem_req && !alu_src_a && alu_src_b == 2'b11 && alu_op == 2'b00) rec.dec_ok++;
      if (alu_src_a && alu_src_b == 2'b10 && alu_op == 2'b00) rec.addr_ok++;
      if (mem_req && iord && !mem_write) rec.mem_rd++;
      if (mem_req && iord && mem_write) rec.mem_wr++;
      rec.reg_w += int'(reg_write);
      if (reg_write && mem_to_reg && !reg_dst) rec.wb_mdr++;
      if (reg_write && reg_dst && !mem_to_reg) rec.wb_rd++;
      if (reg_write && !reg_dst && !mem_to_reg) rec.wb_alu_rt++;
      if (alu_op == 2'b10 && alu_src_a && alu_src_b == 2'b00) rec.funct_ok++;
      if (alu_op == 2'b01 && alu_src_a && alu_src_b == 2'b00 && pc_src == 2'b01) rec.sub_ok++;
      rec.br  += int'(branch);
      rec.bne += int'(branch_ne);
      if (pc_write && pc_src == 2'b10) rec.jmp++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst       = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_strobes", strobes(), 0);
    chk("reset_retired", int'(retired), 0);
    chk("reset_illegal", int'(illegal_op), 0);
    mem_ready = 1'b0;
    rst       = 1'b0;
    #1;
    chk("release_mem_req", int'(mem_req), 1);
    chk("release_alu_src_b", int'(alu_src_b), 1);
    chk("release_ir_write", int'(ir_write), 0);
    model_ret = 0;
    mon_en    = 1'b1;

    // Directed: stalled lw, zero-wait sequence, illegal, 000101, wrap run
    issue(6'b100011, 2, 1);
    issue(6'b000000, 0, 0);
    issue(6'b001000, 0, 0);
    issue(6'b101011, 0, 0);
    issue(6'b000100, 0, 0);
    issue(6'b000010, 0, 0);
    issue(6'b111111, 0, 0);
    issue(6'b000101, 0, 0);
    for (int i = 0; i < 17; i++) issue(6'b000000, 0, 0);
    for (int i = 0; i < 40; i++) random_instr();
    drain();

    // Reset while an R-type sits in EXEC
    mon_en = 1'b0;
    cyc(1'b1, rop());
    cyc(rbit(), 6'b000000);
    chk("exec_alu_op", int'(alu_op), 2);
    #1;
    mem_ready = 1'b1;
    rst       = 1'b1;
    #1;
    chk("midrst_strobes", strobes(), 0);
    chk("midrst_retired", int'(retired), 0);
    @(posedge clk);
    #1;
    chk("midrst_hold_strobes", strobes(), 0);
    mem_ready = 1'b0;
    rst       = 1'b0;
    #1;
    chk("midrst_release_mem_req", int'(mem_req), 1);
    chk("midrst_release_iord", int'(iord), 0);
    chk("midrst_release_alu_src_b", int'(alu_src_b), 1);
    model_ret = 0;
    mon_en    = 1'b1;

    for (int i = 0; i < 30; i++) random_instr();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
